// File: rtl/key_conditioner.sv
// key_conditioner
//   Conditions a bouncing push-button and three bouncing slide switches into
//   clean, clk-synchronous control signals.
//   - The button path delivers a debounced level and a single-cycle press
//     strobe, which feeds the light-pattern stage's start input.
//   - The switch path delivers a debounced 3-bit value, which feeds the
//     pattern-select input, plus a single-cycle change strobe.
//
// Parameters
//   DEBOUNCE_CYCLES : input stability time in clk cycles (2 .. 2^31)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   button_in  in   raw push-button, active-high, asynchronous
//   switch_in  in   [2:0] raw slide switches, asynchronous
//   btn_level  out  debounced button level (registered)
//   btn_pulse  out  one-cycle strobe per debounced press
//   switch_out out  [2:0] debounced switch value
//   switch_chg out  one-cycle strobe when switch_out changes
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_in,
  input  logic [2:0] switch_in,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic [2:0] switch_out,
  output logic       switch_chg
);

  localparam logic [31:0] CNT_LAST = DEBOUNCE_CYCLES - 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  logic       btn_sync_p0;
  logic       btn_sync_p1;
  logic [2:0] sw_sync_p0;
  logic [2:0] sw_sync_p1;
  logic       btn_s;
  logic [2:0] sw_s;

  btn_state_t state;
  btn_state_t state_nxt;
  logic [31:0] btn_cnt;
  logic [31:0] btn_cnt_nxt;
  logic        pulse_nxt;
  logic        level_nxt;

  logic [2:0]  sw_cand;
  logic [31:0] sw_cnt;

  // ---- Stage p0/p1: two-flop synchronizers for the asynchronous inputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      sw_sync_p0  <= 3'b000;
      sw_sync_p1  <= 3'b000;
    end else begin
      btn_sync_p0 <= button_in;
      btn_sync_p1 <= btn_sync_p0;
      sw_sync_p0  <= switch_in;
      sw_sync_p1  <= sw_sync_p0;
    end
  end

  assign btn_s = btn_sync_p1;
  assign sw_s  = sw_sync_p1;

  // ---- Button debounce FSM: state register and registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      btn_cnt   <= 32'd0;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      btn_cnt   <= btn_cnt_nxt;
      btn_pulse <= pulse_nxt;
      btn_level <= level_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    btn_cnt_nxt = btn_cnt;
    pulse_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt   = PRESS_WAIT;
          btn_cnt_nxt = 32'd0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (btn_cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          pulse_nxt = 1'b1;
        end else begin
          btn_cnt_nxt = btn_cnt + 32'd1;
        end
      end
      PRESSED: begin
        // Counter is frozen here, so a held button never re-triggers.
        if (!btn_s) begin
          state_nxt   = RELEASE_WAIT;
          btn_cnt_nxt = 32'd0;
        end
      end
      RELEASE_WAIT: begin
        // A short low glitch drops straight back to PRESSED without a pulse.
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (btn_cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          btn_cnt_nxt = btn_cnt + 32'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        btn_cnt_nxt = 32'd0;
      end
    endcase
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

  // ---- Switch debounce: whole 3-bit word is debounced as one value ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_cand    <= 3'b000;
      sw_cnt     <= 32'd0;
      switch_out <= 3'b000;
      switch_chg <= 1'b0;
    end else begin
      switch_chg <= 1'b0;
      if (sw_s != sw_cand) begin
        sw_cand <= sw_s;
        sw_cnt  <= 32'd0;
      end else begin
        // Saturate at the terminal count; a stable value keeps it there.
        if (sw_cnt != CNT_LAST) begin
          sw_cnt <= sw_cnt + 32'd1;
        end else if (sw_cand != switch_out) begin
          switch_out <= sw_cand;
          switch_chg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
//   Directed bench for key_conditioner with DEBOUNCE_CYCLES=4: a cycle table
//   of {inputs, expected outputs} plus hand-written multi-cycle sequences.
module tb_key_conditioner;

  logic       clk;
  logic       rst;
  logic       button_in;
  logic [2:0] switch_in;
  logic       btn_level;
  logic       btn_pulse;
  logic [2:0] switch_out;
  logic       switch_chg;

  int errors = 0;
  int checks = 0;

  key_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .button_in  (button_in),
    .switch_in  (switch_in),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .switch_out (switch_out),
    .switch_chg (switch_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       btn;
    logic [2:0] sw;
    logic       lvl;
    logic       pls;
    logic [2:0] swo;
    logic       chg;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int n, input logic btn, input logic [2:0] sw,
                     input logic lvl, input logic pls, input logic [2:0] swo,
                     input logic chg);
    vec_t v;
    v.btn = btn; v.sw = sw; v.lvl = lvl; v.pls = pls; v.swo = swo; v.chg = chg;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int npulse;
    int first;
    int badlvl;
    int nchg;
    int badsw;

    rst       = 1'b1;
    button_in = 1'b0;
    switch_in = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level", btn_level, 0);
    chk("reset_pulse", btn_pulse, 0);
    chk("reset_swout", switch_out, 0);
    chk("reset_chg",   switch_chg, 0);
    rst = 1'b0;

    // Row i: inputs applied before edge i; outputs checked just after it.
    // Clean press + simultaneous switch 000->011 sampled on edge 0.
    add(6,  1, 3'b011, 0, 0, 3'b000, 0);
    add(1,  1, 3'b011, 1, 1, 3'b011, 1);
    add(13, 1, 3'b011, 1, 0, 3'b011, 0);
    // Release sampled on edge 20: level drops after edge 26.
    add(6,  0, 3'b011, 1, 0, 3'b011, 0);
    add(4,  0, 3'b011, 0, 0, 3'b011, 0);
    // Switch 011->101 sampled on edge 30: update after edge 36.
    add(6,  0, 3'b101, 0, 0, 3'b011, 0);
    add(1,  0, 3'b101, 0, 0, 3'b101, 1);
    add(3,  0, 3'b101, 0, 0, 3'b101, 0);

    foreach (tbl[i]) begin
      button_in = tbl[i].btn;
      switch_in = tbl[i].sw;
      step();
      chk($sformatf("tbl%0d_level", i), btn_level,  tbl[i].lvl);
      chk($sformatf("tbl%0d_pulse", i), btn_pulse,  tbl[i].pls);
      chk($sformatf("tbl%0d_swout", i), switch_out, tbl[i].swo);
      chk($sformatf("tbl%0d_chg",   i), switch_chg, tbl[i].chg);
    end

    // Bounce: toggle every 2 cycles for 12 cycles, then hold high.
    // Final rise sampled at edge 12 -> single pulse after edge 18.
    npulse = 0;
    first  = -1;
    for (int k = 0; k < 32; k++) begin
      button_in = (k < 12) ? (((k / 2) % 2) == 0) : 1'b1;
      step();
      if (btn_pulse) begin
        npulse++;
        if (first < 0) first = k;
      end
    end
    chk("bounce_npulse", npulse, 1);
    chk("bounce_edge", first, 18);
    chk("bounce_level", btn_level, 1);

    // Two-cycle low glitch while pressed: level stays high, no pulse.
    npulse = 0;
    badlvl = 0;
    for (int k = 0; k < 15; k++) begin
      button_in = (k < 2) ? 1'b0 : 1'b1;
      step();
      if (btn_pulse) npulse++;
      if (btn_level !== 1'b1) badlvl++;
    end
    chk("glitch_npulse", npulse, 0);
    chk("glitch_badlvl", badlvl, 0);

    // Switch 101->100->101 within 3 cycles: no change, no strobe.
    nchg  = 0;
    badsw = 0;
    for (int k = 0; k < 15; k++) begin
      switch_in = (k == 1) ? 3'b100 : 3'b101;
      step();
      if (switch_chg) nchg++;
      if (switch_out !== 3'b101) badsw++;
    end
    chk("swglitch_nchg", nchg, 0);
    chk("swglitch_badsw", badsw, 0);

    // Release fully back to IDLE.
    button_in = 1'b0;
    repeat (12) step();
    chk("idle_level", btn_level, 0);

    // Press, then reset while in PRESS_WAIT with counter=2 (after edge 4).
    button_in = 1'b1;
    npulse = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (btn_pulse) npulse++;
    end
    rst = 1'b1;
    #1;
    chk("midrst_level", btn_level, 0);
    chk("midrst_pulse", btn_pulse, 0);
    chk("midrst_swout", switch_out, 0);
    chk("midrst_chg",   switch_chg, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      if (btn_pulse) npulse++;
    end
    chk("midrst_npulse", npulse, 0);
    rst = 1'b0;

    // Button held and switches at 101 through reset release: both strobes
    // after edge 6 counting from the first edge after release.
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("post%0d_pulse", k), btn_pulse,  (k == 6));
      chk($sformatf("post%0d_chg",   k), switch_chg, (k == 6));
      chk($sformatf("post%0d_level", k), btn_level,  (k >= 6));
      chk($sformatf("post%0d_swout", k), switch_out, (k >= 6) ? 3'b101 : 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
